// File: rtl/btn_pulse_gen.sv
// Push-button front end: per-channel 2-FF synchronizer, debounce and hold-to-repeat FSM
// producing registered level, press/repeat strobe and release strobe on clk.
module btn_pulse_gen #(
    parameter int unsigned N_BTN    = 2,
    parameter int unsigned DEB_CNT  = 1000000,
    parameter int unsigned HOLD_CNT = 50000000,
    parameter int unsigned REP_CNT  = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] rep_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] pulse,
    output logic [N_BTN-1:0] rel_pulse
);

    localparam logic [31:0] DebLast  = 32'(DEB_CNT - 1);
    localparam logic [31:0] HoldLast = 32'(HOLD_CNT - 1);
    localparam logic [31:0] RepLast  = 32'(REP_CNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDebOn,
        StHeld,
        StRepeat,
        StDebOff
    } state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_e      state_q;
        logic [31:0] cnt_q;
        logic        level_q;
        logic        pulse_q;
        logic        rel_q;
        logic        s;

        assign s = sync2_q[i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                rel_q   <= 1'b0;
                case (state_q)
                    StIdle: begin
                        if (s) begin
                            state_q <= StDebOn;
                            cnt_q   <= '0;
                        end
                    end
                    StDebOn: begin
                        if (!s) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else if (cnt_q == DebLast) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    StHeld: begin
                        if (!s) begin
                            state_q <= StDebOff;
                            cnt_q   <= '0;
                        end else if (!rep_en[i]) begin
                            cnt_q <= '0;
                        end else if (cnt_q == HoldLast) begin
                            state_q <= StRepeat;
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    StRepeat: begin
                        if (!s) begin
                            state_q <= StDebOff;
                            cnt_q   <= '0;
                        end else if (!rep_en[i]) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                        end else if (cnt_q == RepLast) begin
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    StDebOff: begin
                        // A bounce back to pressed is absorbed and restarts the hold timer.
                        if (s) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                        end else if (cnt_q == DebLast) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            rel_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign level[i]     = level_q;
        assign pulse[i]     = pulse_q;
        assign rel_pulse[i] = rel_q;
    end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen with short debounce/hold/repeat counts.
module tb_btn_pulse_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] rep_en;
    logic [1:0] level;
    logic [1:0] pulse;
    logic [1:0] rel_pulse;

    int checks = 0;
    int errors = 0;

    btn_pulse_gen #(
        .N_BTN   (2),
        .DEB_CNT (4),
        .HOLD_CNT(10),
        .REP_CNT (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .rep_en   (rep_en),
        .level    (level),
        .pulse    (pulse),
        .rel_pulse(rel_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] lv, input logic [1:0] pl,
                       input logic [1:0] rl);
        checks++;
        assert ({level, pulse, rel_pulse} === {lv, pl, rl})
        else begin
            errors++;
            $error("FAIL %s: level/pulse/rel_pulse got %b/%b/%b want %b/%b/%b",
                   tag, level, pulse, rel_pulse, lv, pl, rl);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst    = 1'b0;
        btn_in = 2'b00;
        rep_en = 2'b00;
        step();
        step();
        chk("reset", 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        step();
        chk("idle", 2'b00, 2'b00, 2'b00);

        // Clean press: captured at edge 1, strobe after edge 7
        btn_in = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t1_deb", 2'b00, 2'b00, 2'b00);
        end
        step();
        chk("t1_press", 2'b01, 2'b01, 2'b00);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t1_hold", 2'b01, 2'b00, 2'b00);
        end

        // Clean release, symmetric timing
        btn_in = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t1_rel_deb", 2'b01, 2'b00, 2'b00);
        end
        step();
        chk("t1_release", 2'b00, 2'b00, 2'b01);
        step();
        chk("t1_idle", 2'b00, 2'b00, 2'b00);

        // Bouncy press 1,0,1,0 then steady 1
        btn_in = 2'b01; step(); chk("t2_bounce", 2'b00, 2'b00, 2'b00);
        btn_in = 2'b00; step(); chk("t2_bounce", 2'b00, 2'b00, 2'b00);
        btn_in = 2'b01; step(); chk("t2_bounce", 2'b00, 2'b00, 2'b00);
        btn_in = 2'b00; step(); chk("t2_bounce", 2'b00, 2'b00, 2'b00);
        btn_in = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2_deb", 2'b00, 2'b00, 2'b00);
        end
        step();
        chk("t2_press", 2'b01, 2'b01, 2'b00);

        // Auto-repeat: pulses at P+10, P+13, P+16
        rep_en = 2'b01;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("t3_rep", 2'b01, (k == 10 || k == 13 || k == 16) ? 2'b01 : 2'b00, 2'b00);
        end
        rep_en = 2'b00;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t3_stop", 2'b01, 2'b00, 2'b00);
        end

        // Two-cycle release glitch restarts the hold timer: repeat at g15, not g10
        rep_en = 2'b01;
        btn_in = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) btn_in = 2'b01;
            step();
            chk("t4_glitch", 2'b01, (k == 15) ? 2'b01 : 2'b00, 2'b00);
        end

        // Asynchronous reset while in REPEAT
        #1;
        rst = 1'b0;
        #1;
        chk("t5_async", 2'b00, 2'b00, 2'b00);
        rep_en = 2'b00;
        step();
        chk("t5_in_rst", 2'b00, 2'b00, 2'b00);
        step();
        chk("t5_in_rst", 2'b00, 2'b00, 2'b00);
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t5_deb", 2'b00, 2'b00, 2'b00);
        end
        step();
        chk("t5_press", 2'b01, 2'b01, 2'b00);
        step();
        chk("t5_hold", 2'b01, 2'b00, 2'b00);

        // Independence between channels
        btn_in = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t6_rel0_deb", 2'b01, 2'b00, 2'b00);
        end
        step();
        chk("t6_rel0", 2'b00, 2'b00, 2'b01);
        btn_in = 2'b11;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t6_both_deb", 2'b00, 2'b00, 2'b00);
        end
        step();
        chk("t6_both_press", 2'b11, 2'b11, 2'b00);
        step();
        chk("t6_both_hold", 2'b11, 2'b00, 2'b00);
        btn_in = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t6_rel1_deb", 2'b11, 2'b00, 2'b00);
        end
        step();
        chk("t6_rel1", 2'b01, 2'b00, 2'b10);
        step();
        chk("t6_after", 2'b01, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
